// File: rtl/dvp_capture_ctrl.sv
// DVP frame-capture controller: frame tracking, byte-to-word packing, 2-entry write buffer.
// Optional build macro DVP_CAPTURE_BYTE_SWAP_EN puts the first byte of each word in bits 31:24.
//
//   state   | meaning
//   IDLE    | capture disabled, waiting for cap_en
//   WAIT_FS | armed, waiting for frame start (VSYNC falling)
//   ACTIVE  | accepting bytes, waiting for frame end (VSYNC rising)
//   FLUSH   | push any partial word, wait for buffer to drain
//   DONE    | one-cycle frame-complete pulse
//   HALT    | single-shot finished, waiting for cap_en to drop
module dvp_capture_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CONF_DATA_W = 32,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CONF_DATA_W-1:0] dvp_conf_i,
    input  logic [CONF_DATA_W-1:0] pxl_mem_base_i,
    input  logic                   dvp_vsync_i,
    input  logic                   dvp_href_i,
    input  logic                   dvp_byte_vld_i,
    input  logic [7:0]             dvp_data_i,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic [DATA_W-1:0]      wr_data_o,
    output logic                   wr_vld_o,
    input  logic                   wr_rdy_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   ovf_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FS, S_ACTIVE, S_FLUSH, S_DONE, S_HALT
    } state_t;

    state_t state_q, state_d;

    logic                   cap_en, continuous;
    logic                   vsync_q, fs, fe;
    logic                   abort;
    logic [ADDR_W-1:0]      base_q, offset_q;
    logic [1:0]             byte_cnt_q;
    logic [1:0]             lane;
    logic [DATA_W-1:0]      word_q, word_upd;
    logic                   byte_acc, pack_push, flush_push;
    logic                   push, pop, push_ok, drop;
    logic [ADDR_W-1:0]      push_addr;
    logic [DATA_W-1:0]      push_data;
    logic [ADDR_W-1:0]      addr_mem [2];
    logic [DATA_W-1:0]      data_mem [2];
    logic                   rd_ptr, wr_ptr;
    logic [1:0]             count_q;
    logic                   full, empty;
    logic                   unused_cfg;

    assign cap_en     = dvp_conf_i[0];
    assign continuous = dvp_conf_i[1];
    assign unused_cfg = ^{dvp_conf_i, pxl_mem_base_i};

    assign fs = vsync_q & ~dvp_vsync_i;
    assign fe = ~vsync_q & dvp_vsync_i;

    assign abort = ~cap_en & ((state_q == S_WAIT_FS) | (state_q == S_ACTIVE) |
                              (state_q == S_FLUSH));

    // Bytes in the abort cycle are not accepted so nothing from an aborted frame is pushed late.
    assign byte_acc   = (state_q == S_ACTIVE) & cap_en & dvp_href_i & dvp_byte_vld_i;
    assign pack_push  = byte_acc & (byte_cnt_q == 2'd3);
    assign flush_push = (state_q == S_FLUSH) & cap_en & (byte_cnt_q != 2'd0);

`ifdef DVP_CAPTURE_BYTE_SWAP_EN
    assign lane = 2'd3 - byte_cnt_q;
`else
    assign lane = byte_cnt_q;
`endif

    always_comb begin
        word_upd = word_q;
        word_upd[{lane, 3'b000} +: 8] = dvp_data_i;
    end

    // word_q only ever holds bytes of the current word, so unfilled lanes are already zero.
    assign push      = pack_push | flush_push;
    assign push_data = flush_push ? word_q : word_upd;
    assign push_addr = base_q + offset_q;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign pop     = ~empty & wr_rdy_i;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= dvp_vsync_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (cap_en) state_d = S_WAIT_FS;
            S_WAIT_FS: if (!cap_en) state_d = S_IDLE;
                       else if (fs) state_d = S_ACTIVE;
            S_ACTIVE:  if (!cap_en) state_d = S_IDLE;
                       else if (fe) state_d = S_FLUSH;
            S_FLUSH:   if (!cap_en) state_d = S_IDLE;
                       else if ((byte_cnt_q == 2'd0) && empty) state_d = S_DONE;
            S_DONE:    state_d = (continuous && cap_en) ? S_WAIT_FS : S_HALT;
            S_HALT:    if (!cap_en) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign busy_o       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign frame_done_o = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            offset_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else if ((state_q == S_WAIT_FS) && cap_en && fs) begin
            base_q     <= pxl_mem_base_i[ADDR_W-1:0];
            offset_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else if (byte_acc) begin
            if (byte_cnt_q == 2'd3) begin
                word_q     <= '0;
                byte_cnt_q <= '0;
                offset_q   <= offset_q + ADDR_W'(4);
            end else begin
                word_q     <= word_upd;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
        end else if (flush_push) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            offset_q   <= offset_q + ADDR_W'(4);
        end else if (abort) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_o <= '0;
            ovf_o       <= 1'b0;
        end else begin
            if (state_q == S_DONE) frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
            if (!cap_en)           ovf_o <= 1'b0;
            else if (drop)         ovf_o <= 1'b1;
        end
    end

    // When full, wr_ptr == rd_ptr: a simultaneous push refills the slot being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign wr_vld_o  = ~empty;
    assign wr_addr_o = addr_mem[rd_ptr];
    assign wr_data_o = data_mem[rd_ptr];

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl: per-cycle vector table for a single-shot frame,
// then hand-written sequences for flush, backpressure/overflow, continuous mode and abort.
module tb_dvp_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dvp_conf_i, pxl_mem_base_i;
    logic        dvp_vsync_i, dvp_href_i, dvp_byte_vld_i;
    logic [7:0]  dvp_data_i;
    logic [31:0] wr_addr_o, wr_data_o;
    logic        wr_vld_o, wr_rdy_i;
    logic        busy_o, frame_done_o, ovf_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];

    typedef struct {
        logic [1:0]  conf;
        logic        vsync;
        logic        href;
        logic        vld;
        logic [7:0]  data;
        logic        e_vld;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[14];

    dvp_capture_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .dvp_conf_i     (dvp_conf_i),
        .pxl_mem_base_i (pxl_mem_base_i),
        .dvp_vsync_i    (dvp_vsync_i),
        .dvp_href_i     (dvp_href_i),
        .dvp_byte_vld_i (dvp_byte_vld_i),
        .dvp_data_i     (dvp_data_i),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_vld_o       (wr_vld_o),
        .wr_rdy_i       (wr_rdy_i),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .ovf_o          (ovf_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always #5 clk = ~clk;

    // Transfers and done pulses are recorded mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst && wr_vld_o && wr_rdy_i) got_q.push_back({wr_addr_o, wr_data_o});
        if (!rst && frame_done_o) done_cnt++;
    end

    function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
`ifdef DVP_CAPTURE_BYTE_SWAP_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        dvp_href_i = 1'b1; dvp_byte_vld_i = 1'b1; dvp_data_i = b;
        tick();
        dvp_href_i = 1'b0; dvp_byte_vld_i = 1'b0;
    endtask

    task automatic do_fs();
        dvp_vsync_i = 1'b1; tick();
        dvp_vsync_i = 1'b0; tick();
    endtask

    task automatic do_fe();
        dvp_vsync_i = 1'b1; tick();
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 30 && !frame_done_o; n++) tick();
        chk({nm, "_done_seen"}, 64'(frame_done_o), 64'd1);
    endtask

    task automatic check_words(input string nm);
        chk({nm, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_word%0d", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dvp_conf_i = '0; pxl_mem_base_i = '0;
        dvp_vsync_i = 1'b0; dvp_href_i = 1'b0; dvp_byte_vld_i = 1'b0;
        dvp_data_i = '0; wr_rdy_i = 1'b1;

        //        conf  vs  hr  vl  data   e_vld e_addr        e_data                          busy done cnt
        vt[0]  = '{2'd1, 1, 0, 0, 8'h00, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[1]  = '{2'd1, 0, 1, 1, 8'hEE, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[2]  = '{2'd1, 0, 1, 1, 8'h01, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[3]  = '{2'd1, 0, 1, 1, 8'h02, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[4]  = '{2'd1, 0, 1, 1, 8'h03, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[5]  = '{2'd1, 0, 1, 1, 8'h04, 1, 32'h1000_0000, pack4(8'h01,8'h02,8'h03,8'h04), 1, 0, 16'd0};
        vt[6]  = '{2'd1, 0, 1, 1, 8'h05, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[7]  = '{2'd1, 0, 1, 1, 8'h06, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[8]  = '{2'd1, 0, 1, 1, 8'h07, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[9]  = '{2'd1, 0, 1, 1, 8'h08, 1, 32'h1000_0004, pack4(8'h05,8'h06,8'h07,8'h08), 1, 0, 16'd0};
        vt[10] = '{2'd1, 1, 0, 0, 8'h00, 0, 32'h0,        32'h0,                             1, 0, 16'd0};
        vt[11] = '{2'd1, 1, 0, 0, 8'h00, 0, 32'h0,        32'h0,                             1, 1, 16'd0};
        vt[12] = '{2'd1, 1, 0, 0, 8'h00, 0, 32'h0,        32'h0,                             0, 0, 16'd1};
        vt[13] = '{2'd0, 1, 0, 0, 8'h00, 0, 32'h0,        32'h0,                             0, 0, 16'd1};

        tick(); tick(); tick();
        chk("rst_vld",  64'(wr_vld_o), 64'd0);
        chk("rst_addr", 64'(wr_addr_o), 64'd0);
        chk("rst_data", 64'(wr_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(frame_done_o), 64'd0);
        chk("rst_ovf",  64'(ovf_o), 64'd0);
        chk("rst_cnt",  64'(frame_cnt_o), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // single-shot frame, one vector per clock
        pxl_mem_base_i = 32'h1000_0000;
        for (int i = 0; i < 14; i++) begin
            dvp_conf_i     = {30'd0, vt[i].conf};
            dvp_vsync_i    = vt[i].vsync;
            dvp_href_i     = vt[i].href;
            dvp_byte_vld_i = vt[i].vld;
            dvp_data_i     = vt[i].data;
            tick();
            chk($sformatf("v%0d_vld", i), 64'(wr_vld_o), 64'(vt[i].e_vld));
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d_addr", i), 64'(wr_addr_o), 64'(vt[i].e_addr));
                chk($sformatf("v%0d_data", i), 64'(wr_data_o), 64'(vt[i].e_data));
            end
            chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(vt[i].e_busy));
            chk($sformatf("v%0d_done", i), 64'(frame_done_o), 64'(vt[i].e_done));
            chk($sformatf("v%0d_cnt", i), 64'(frame_cnt_o), 64'(vt[i].e_cnt));
        end
        dvp_href_i = 1'b0; dvp_byte_vld_i = 1'b0;
        exp_q.push_back({32'h1000_0000, pack4(8'h01, 8'h02, 8'h03, 8'h04)});
        exp_q.push_back({32'h1000_0004, pack4(8'h05, 8'h06, 8'h07, 8'h08)});
        check_words("single");
        chk("single_pulses", 64'(done_cnt), 64'd1);

        // partial word flush
        pxl_mem_base_i = 32'h3000_0000;
        dvp_conf_i = 32'd1; tick();
        do_fs();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        do_fe();
        chk("flush_empty_at_fe", 64'(wr_vld_o), 64'd0);
        tick();
        chk("flush_pad_vld",  64'(wr_vld_o), 64'd1);
        chk("flush_pad_addr", 64'(wr_addr_o), 64'h3000_0004);
        chk("flush_pad_data", 64'(wr_data_o), 64'(pack4(8'hA4, 8'h00, 8'h00, 8'h00)));
        wait_done("flush");
        chk("flush_drained_at_done", 64'(wr_vld_o), 64'd0);
        tick();
        chk("flush_cnt", 64'(frame_cnt_o), 64'd2);
        chk("flush_halt_busy", 64'(busy_o), 64'd0);
        dvp_conf_i = 32'd0; tick();
        exp_q.push_back({32'h3000_0000, pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3)});
        exp_q.push_back({32'h3000_0004, pack4(8'hA4, 8'h00, 8'h00, 8'h00)});
        check_words("flush");

        // backpressure and overflow
        pxl_mem_base_i = 32'h4000_0000;
        wr_rdy_i = 1'b0;
        dvp_conf_i = 32'd1; tick();
        do_fs();
        for (int i = 0; i < 12; i++) begin
            send_byte(8'h10 + 8'(i));
            if (i >= 3)
                chk($sformatf("bp_head_b%0d", i), {wr_vld_o, wr_addr_o, wr_data_o},
                    {1'b1, 32'h4000_0000, pack4(8'h10, 8'h11, 8'h12, 8'h13)});
            if (i == 7) chk("bp_no_ovf_when_full", 64'(ovf_o), 64'd0);
        end
        chk("bp_ovf_set", 64'(ovf_o), 64'd1);
        wr_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        do_fe();
        wait_done("bp");
        tick();
        chk("bp_ovf_sticky", 64'(ovf_o), 64'd1);
        chk("bp_cnt", 64'(frame_cnt_o), 64'd3);
        dvp_conf_i = 32'd0; tick();
        chk("bp_ovf_clear", 64'(ovf_o), 64'd0);
        exp_q.push_back({32'h4000_0000, pack4(8'h10, 8'h11, 8'h12, 8'h13)});
        exp_q.push_back({32'h4000_0004, pack4(8'h14, 8'h15, 8'h16, 8'h17)});
        exp_q.push_back({32'h4000_000C, pack4(8'h20, 8'h21, 8'h22, 8'h23)});
        check_words("bp");

        // continuous mode, base changed between frames
        pxl_mem_base_i = 32'h5000_0000;
        dvp_conf_i = 32'd3; tick();
        for (int f = 0; f < 3; f++) begin
            do_fs();
            for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(f * 16 + i));
            do_fe();
            wait_done($sformatf("cont_f%0d", f));
            pxl_mem_base_i = 32'h2000_0000;
        end
        dvp_conf_i = 32'd0; tick(); tick();
        chk("cont_cnt", 64'(frame_cnt_o), 64'd6);
        chk("cont_idle_busy", 64'(busy_o), 64'd0);
        chk("cont_pulses", 64'(done_cnt), 64'd6);
        exp_q.push_back({32'h5000_0000, pack4(8'h30, 8'h31, 8'h32, 8'h33)});
        exp_q.push_back({32'h2000_0000, pack4(8'h40, 8'h41, 8'h42, 8'h43)});
        exp_q.push_back({32'h2000_0000, pack4(8'h50, 8'h51, 8'h52, 8'h53)});
        check_words("cont");

        // abort after 6 bytes, then a clean frame to show no leftover partial bytes
        pxl_mem_base_i = 32'h6000_0000;
        dvp_conf_i = 32'd1; tick();
        do_fs();
        for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
        chk("abort_busy_before", 64'(busy_o), 64'd1);
        dvp_conf_i = 32'd0; tick();
        chk("abort_idle_next", 64'(busy_o), 64'd0);
        tick(); tick(); tick();
        chk("abort_vld", 64'(wr_vld_o), 64'd0);
        chk("abort_cnt", 64'(frame_cnt_o), 64'd6);
        chk("abort_no_done", 64'(done_cnt), 64'd6);
        exp_q.push_back({32'h6000_0000, pack4(8'h60, 8'h61, 8'h62, 8'h63)});
        check_words("abort");
        dvp_conf_i = 32'd1; tick();
        do_fs();
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
        tick(); tick();
        dvp_conf_i = 32'd0; tick();
        exp_q.push_back({32'h6000_0000, pack4(8'h70, 8'h71, 8'h72, 8'h73)});
        check_words("restart");
        chk("restart_cnt", 64'(frame_cnt_o), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
